gpio_port: RTL and testbench

GPIO_PORT -- requirements
Module: gpio_port

---
 rtl/gpio_pkg.sv | 13 +
 rtl/gpio_sync.sv | 26 ++
 rtl/gpio_port.sv | 107 ++++++++++
 tb/tb_gpio_port.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared GPIO constants and debounce state type.
// Debounce logic is enabled with GPIO_DEBOUNCE_EN.
package gpio_pkg;

  localparam int GPIO_WIDTH = 32;
  localparam int GPIO_DEBOUNCE_CYCLES = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } db_state_t;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for the asynchronous input pins.
// Used by gpio_port.
module gpio_sync
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_port.sv
// GPIO port: registered outputs, synchronized inputs, read strobe,
// sticky change flag. Define GPIO_DEBOUNCE_EN to add input debouncing.
module gpio_port
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gpio_out_en,
  input  logic             gpio_in_en,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] gpio_out,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] rdata,
  output logic             rdata_valid,
  output logic             gpio_changed
);

  logic [WIDTH-1:0] sync_in;
  logic [WIDTH-1:0] stable_in;
  logic [WIDTH-1:0] stable_prev;

  gpio_sync #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (gpio_in),
    .q  (sync_in)
  );

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  db_state_t        state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] cand;

  // cand remembers the value being timed so a third value restarts the count
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      stable_q <= '0;
      cand     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sync_in != stable_q) begin
            state <= COUNT;
            cnt   <= '0;
            cand  <= sync_in;
          end
        end
        COUNT: begin
          if (sync_in == stable_q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (sync_in != cand) begin
            cand <= sync_in;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            stable_q <= sync_in;
            state    <= IDLE;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign stable_in = stable_q;
`else
  localparam int unused_debounce = DEBOUNCE_CYCLES;

  assign stable_in = sync_in;
`endif

  // a change arriving with a read wins, so no change is lost
  always_ff @(posedge clk) begin
    if (rst) begin
      gpio_out     <= '0;
      rdata        <= '0;
      rdata_valid  <= 1'b0;
      gpio_changed <= 1'b0;
      stable_prev  <= '0;
    end else begin
      rdata_valid <= gpio_in_en;
      stable_prev <= stable_in;
      if (gpio_out_en) gpio_out <= wdata;
      if (gpio_in_en) rdata <= stable_in;
      gpio_changed <= (stable_in != stable_prev) |
                      (gpio_changed & ~gpio_in_en);
    end
  end

endmodule

// File: tb/tb_gpio_port.sv
// Directed testbench for gpio_port: vector table plus corner sequences.
// Debounce sequences run when GPIO_DEBOUNCE_EN is defined.
module tb_gpio_port;

  localparam int W = 32;
`ifdef GPIO_DEBOUNCE_EN
  localparam int SETTLE = 8;
`else
  localparam int SETTLE = 3;
`endif

  logic         clk;
  logic         rst;
  logic         gpio_out_en;
  logic         gpio_in_en;
  logic [W-1:0] wdata;
  logic [W-1:0] gpio_out;
  logic [W-1:0] gpio_in;
  logic [W-1:0] rdata;
  logic         rdata_valid;
  logic         gpio_changed;

  gpio_port #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .gpio_out_en (gpio_out_en),
    .gpio_in_en  (gpio_in_en),
    .wdata       (wdata),
    .gpio_out    (gpio_out),
    .gpio_in     (gpio_in),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .gpio_changed(gpio_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic         rd;
    logic [W-1:0] wd;
    logic [W-1:0] pins;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_rdata;
    logic         exp_valid;
    logic         exp_chg;
  } vec_t;

  vec_t tbl[8];
  int   n_run;
  int   n_fail;

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_read();
    gpio_in_en = 1'b1;
    step(1);
    gpio_in_en = 1'b0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    tbl[0] = '{1, 0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0};
    tbl[1] = '{0, 1, 32'h0, 32'hA5, 32'hDEADBEEF, 32'hA5, 1, 0};
    tbl[2] = '{1, 1, 32'h1, 32'h2, 32'h1, 32'h2, 1, 0};
    tbl[3] = '{0, 0, 32'h0, 32'hFFFF0000, 32'h1, 32'h2, 0, 1};
    tbl[4] = '{1, 0, 32'h0, 32'hFFFF0000, 32'h0, 32'h2, 0, 1};
    tbl[5] = '{0, 1, 32'h0, 32'hFFFF0000, 32'h0, 32'hFFFF0000, 1, 0};
    tbl[6] = '{1, 1, 32'h5A5A5A5A, 32'h12345678, 32'h5A5A5A5A,
               32'h12345678, 1, 0};
    tbl[7] = '{0, 0, 32'h0, 32'h12345678, 32'h5A5A5A5A,
               32'h12345678, 0, 0};

    // reset with strobes and a pin glitch that are all ignored
    rst         = 1'b1;
    gpio_out_en = 1'b1;
    gpio_in_en  = 1'b1;
    wdata       = 32'hFFFFFFFF;
    gpio_in     = 32'hF0F0F0F0;
    step(2);
    gpio_in = '0;
    step(3);
    rst         = 1'b0;
    gpio_out_en = 1'b0;
    gpio_in_en  = 1'b0;
    check("rst_out", gpio_out, '0);
    check("rst_rdata", rdata, '0);
    check("rst_valid", {31'b0, rdata_valid}, '0);
    check("rst_chg", {31'b0, gpio_changed}, '0);
    step(SETTLE + 2);
    check("post_rst_out", gpio_out, '0);
    check("post_rst_chg", {31'b0, gpio_changed}, '0);
    check("post_rst_valid", {31'b0, rdata_valid}, '0);

    for (int i = 0; i < 8; i++) begin
      gpio_in = tbl[i].pins;
      step(SETTLE);
      gpio_out_en = tbl[i].wr;
      gpio_in_en  = tbl[i].rd;
      wdata       = tbl[i].wd;
      step(1);
      gpio_out_en = 1'b0;
      gpio_in_en  = 1'b0;
      wdata       = 32'hCAFEF00D;
      check($sformatf("v%0d_out", i), gpio_out, tbl[i].exp_out);
      check($sformatf("v%0d_rdata", i), rdata, tbl[i].exp_rdata);
      check($sformatf("v%0d_valid", i), {31'b0, rdata_valid},
            {31'b0, tbl[i].exp_valid});
      check($sformatf("v%0d_chg", i), {31'b0, gpio_changed},
            {31'b0, tbl[i].exp_chg});
      step(1);
      check($sformatf("v%0d_hold", i), gpio_out, tbl[i].exp_out);
      check($sformatf("v%0d_pulse", i), {31'b0, rdata_valid}, '0);
    end

    // back-to-back reads straddling an input change
    gpio_in = 32'h11;
    step(SETTLE + 1);
    do_read();
    gpio_in = 32'h22;
    step(1);
    gpio_in_en = 1'b1;
    step(1);
    check("b2b_valid0", {31'b0, rdata_valid}, 32'h1);
    check("b2b_rdata0", rdata, 32'h11);
    step(1);
    gpio_in_en = 1'b0;
    check("b2b_valid1", {31'b0, rdata_valid}, 32'h1);
`ifdef GPIO_DEBOUNCE_EN
    check("b2b_rdata1", rdata, 32'h11);
`else
    check("b2b_rdata1", rdata, 32'h22);
`endif
    step(1);
    check("b2b_end", {31'b0, rdata_valid}, '0);
    step(SETTLE + 1);
    do_read();
    check("pre_cor_chg", {31'b0, gpio_changed}, '0);

    // change and read land in the same cycle
    gpio_in = 32'h44;
    step(SETTLE - 1);
    do_read();
    check("cor_chg", {31'b0, gpio_changed}, 32'h1);
    check("cor_rdata", rdata, 32'h44);
    do_read();
    check("cor_clear", {31'b0, gpio_changed}, '0);

    // reset while a read is strobed
    gpio_in_en = 1'b1;
    rst        = 1'b1;
    step(1);
    rst        = 1'b0;
    gpio_in_en = 1'b0;
    check("rr_valid", {31'b0, rdata_valid}, '0);
    check("rr_out", gpio_out, '0);
    check("rr_rdata", rdata, '0);
    check("rr_chg", {31'b0, gpio_changed}, '0);

    gpio_in = '0;
    step(2 * SETTLE);
    do_read();
    check("quiet_chg", {31'b0, gpio_changed}, '0);
`ifdef GPIO_DEBOUNCE_EN
    gpio_in = 32'h1;
    step(2);
    gpio_in = 32'h0;
    step(10);
    check("glitch_chg", {31'b0, gpio_changed}, '0);
    do_read();
    check("glitch_rdata", rdata, '0);
    gpio_in = 32'h1;
    step(6);
    step(3);
    check("db_chg", {31'b0, gpio_changed}, 32'h1);
    do_read();
    check("db_rdata", rdata, 32'h1);
`else
    gpio_in = 32'h1;
    step(1);
    gpio_in = 32'h0;
    step(4);
    check("pulse_chg", {31'b0, gpio_changed}, 32'h1);
    do_read();
    check("pulse_rdata", rdata, '0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
